// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one 4-bit adder slice between two requesters.
// Each accepted add runs nibble-serially, LSB first, with the ripple carry held in a flop.
module adder_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_sum,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             lg_q, lg_d;

    logic [1:0]       grant;
    logic [CW+1:0]    nib_idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_sum;
    logic             last_nib;

    // Arbitration: a tie goes to the requester that was not granted last.
    always_comb begin
        grant = 2'b00;
        if (state_q == S_IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = lg_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    // Shared adder slice working on the current nibble.
    always_comb begin
        nib_idx  = {cnt_q, 2'b00};
        a_nib    = a_q[nib_idx +: 4];
        b_nib    = b_q[nib_idx +: 4];
        nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        last_nib = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        lg_d    = lg_q;

        case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    id_d    = grant[1];
                    lg_d    = grant[1];
                    a_d     = grant[1] ? req1_a : req0_a;
                    b_d     = grant[1] ? req1_b : req0_b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[nib_idx +: 4] = nib_sum[3:0];
                carry_d             = nib_sum[4];
                cnt_d               = cnt_q + CW'(1);
                if (last_nib) begin
                    res_d[WIDTH] = nib_sum[4];
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset leaves last grant at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            lg_q    <= 1'b1;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            lg_q    <= lg_d;
        end
    end

    assign rsp_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_sum   = res_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched (WIDTH=8): directed requests push expected {id,sum},
// a response monitor pops and compares on every accepted result.
module tb_adder_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [8:0] rsp_sum;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    adder_sched #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: each handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {22'd0, rsp_id, rsp_sum}, 32'hFFFF_FFFF);
            end else begin
                check("rsp", {22'd0, rsp_id, rsp_sum}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 just after the accept edge.
    task automatic issue(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic exp_id,
                         input logic [8:0] exp_sum, input bit push);
        bit found;
        req_valid = v;
        req0_a = a0; req0_b = b0;
        req1_a = a1; req1_b = b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) found = 1'b1;
        end
        check("grant", {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
        if (push) exp_q.push_back({exp_id, exp_sum});
        @(posedge clk); #2;
        req_valid = 2'b00;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {18'd0, req_ready, rsp_valid, rsp_id, rsp_sum, busy}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // req0 0x0F+0x01: carry out of nibble 0, latency N+1 = 3
        issue(2'b01, 8'h0F, 8'h01, 8'h00, 8'h00, 1'b0, 9'h010, 1'b1);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = k;
        end
        check("latency", lat, 32'd3);
        @(posedge clk); #2;
        drain();

        // req1 0xFF+0xFF: carry into bit 8
        issue(2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 9'h1FE, 1'b1);
        drain();

        // Both valid continuously: grants alternate 0,1,0,1
        req_valid = 2'b11;
        req0_a = 8'h11; req0_b = 8'h22;
        req1_a = 8'h80; req1_b = 8'h80;
        for (int g = 0; g < 4; g++) begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) found = 1'b1;
            end
            check("alt_grant", {30'd0, req_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
            exp_q.push_back((g % 2 == 0) ? {1'b0, 9'h033} : {1'b1, 9'h100});
            @(posedge clk); #2;
        end
        req_valid = 2'b00;
        drain();

        // Hold DONE with rsp_ready low; competing requests must not be accepted
        rsp_ready = 1'b0;
        issue(2'b01, 8'h5A, 8'h3C, 8'h00, 8'h00, 1'b0, 9'h096, 1'b1);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = k;
        end
        check("hold_reach_done", lat, 32'd3);
        @(posedge clk); #2;
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", {18'd0, rsp_valid, rsp_id, rsp_sum, req_ready, busy},
                  {18'd0, 1'b1, 1'b0, 9'h096, 2'b00, 1'b1});
        end
        @(posedge clk); #2;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain();

        // Reset after nibble 0 aborts; arbitration restarts at requester 0
        issue(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_outs", {18'd0, req_ready, rsp_valid, rsp_id, rsp_sum, busy}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        issue(2'b11, 8'h01, 8'h02, 8'h40, 8'h05, 1'b0, 9'h003, 1'b1);
        drain();

        // Operand change after accept is ignored
        issue(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 9'h046, 1'b1);
        req0_a = 8'hEE;
        drain();

        check("final_queue", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
